// File: rtl/pmci_spi_csr_seq.sv
// Sequencer turning single-word flash requests into the PMCI SPI bridge CSR transaction
// sequence (address, data, command, busy polling, data read) with timeout and error reporting.
module pmci_spi_csr_seq #(
  parameter logic [31:0] SPI_BA   = 32'h20400,
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] avmm_address,
  output logic        avmm_write,
  output logic        avmm_read,
  output logic [31:0] avmm_writedata,
  input  logic        avmm_waitrequest,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid
);

  typedef enum logic [3:0] {
    StIdle,
    StWrAr,
    StWrDr,
    StWrCmd,
    StPollRd,
    StPollWait,
    StPollGap,
    StRdData,
    StRdWait,
    StResp
  } state_e;

  localparam logic [31:0] AddrCsr  = SPI_BA;
  localparam logic [31:0] AddrAr   = SPI_BA + 32'h4;
  localparam logic [31:0] AddrRdDr = SPI_BA + 32'h8;
  localparam logic [31:0] AddrWrDr = SPI_BA + 32'hC;
  localparam logic [7:0]  GapLast  = 8'(POLL_GAP - 1);
  localparam logic [15:0] PollMax  = 16'(POLL_MAX);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] av_addr_q, av_addr_d;
  logic [31:0] av_wdata_q, av_wdata_d;
  logic        av_write_q, av_write_d;
  logic        av_read_q, av_read_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    av_addr_d   = av_addr_q;
    av_wdata_d  = av_wdata_q;
    av_write_d  = av_write_q;
    av_read_d   = av_read_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    // Each transition into a command state loads that state's command, so strobes are registered.
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          wdata_d    = req_wdata;
          err_d      = 1'b0;
          rdata_d    = 32'h0;
          state_d    = StWrAr;
          av_write_d = 1'b1;
          av_read_d  = 1'b0;
          av_addr_d  = AddrAr;
          av_wdata_d = req_addr;
        end
      end
      StWrAr: begin
        if (!avmm_waitrequest) begin
          av_write_d = 1'b1;
          if (write_q) begin
            state_d    = StWrDr;
            av_addr_d  = AddrWrDr;
            av_wdata_d = wdata_q;
          end else begin
            state_d    = StWrCmd;
            av_addr_d  = AddrCsr;
            av_wdata_d = 32'h2;
          end
        end
      end
      StWrDr: begin
        if (!avmm_waitrequest) begin
          state_d    = StWrCmd;
          av_addr_d  = AddrCsr;
          av_wdata_d = 32'h1;
        end
      end
      StWrCmd: begin
        if (!avmm_waitrequest) begin
          state_d    = StPollRd;
          av_write_d = 1'b0;
          av_read_d  = 1'b1;
          av_addr_d  = AddrCsr;
          poll_cnt_d = 16'h0;
        end
      end
      StPollRd: begin
        if (!avmm_waitrequest) begin
          state_d    = StPollWait;
          av_read_d  = 1'b0;
          poll_cnt_d = poll_cnt_q + 16'd1;
        end
      end
      StPollWait: begin
        if (avmm_readdatavalid) begin
          if (avmm_readdata[2]) begin
            if (poll_cnt_q == PollMax) begin
              err_d   = 1'b1;
              state_d = StResp;
            end else begin
              gap_cnt_d = 8'h0;
              state_d   = StPollGap;
            end
          end else if (avmm_readdata[3]) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (write_q) begin
            state_d = StResp;
          end else begin
            state_d   = StRdData;
            av_read_d = 1'b1;
            av_addr_d = AddrRdDr;
          end
        end
      end
      StPollGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StPollRd;
          av_read_d = 1'b1;
          av_addr_d = AddrCsr;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StRdData: begin
        if (!avmm_waitrequest) begin
          state_d   = StRdWait;
          av_read_d = 1'b0;
        end
      end
      StRdWait: begin
        if (avmm_readdatavalid) begin
          rdata_d = avmm_readdata;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = err_q ? 32'h0 : rdata_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      poll_cnt_q  <= 16'h0;
      gap_cnt_q   <= 8'h0;
      av_addr_q   <= 32'h0;
      av_wdata_q  <= 32'h0;
      av_write_q  <= 1'b0;
      av_read_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      av_addr_q   <= av_addr_d;
      av_wdata_q  <= av_wdata_d;
      av_write_q  <= av_write_d;
      av_read_q   <= av_read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gating with rst drops a request presented in a reset cycle.
  assign req_ready      = (state_q == StIdle) && !rst;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign avmm_address   = av_addr_q;
  assign avmm_writedata = av_wdata_q;
  assign avmm_write     = av_write_q;
  assign avmm_read      = av_read_q;

endmodule

// File: tb/tb_pmci_spi_csr_seq.sv
// Bench for pmci_spi_csr_seq: AVMM slave model with CSR/RD_DR response queues, command and
// response scoreboards, latency checks.
module tb_pmci_spi_csr_seq;

  localparam logic [31:0] BA   = 32'h20400;
  localparam int unsigned GAP  = 8;
  localparam int unsigned PMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] avmm_address, avmm_writedata, avmm_readdata;
  logic        avmm_write, avmm_read, avmm_waitrequest, avmm_readdatavalid;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } cmd_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } rsp_t;

  cmd_t        act_q[$];
  cmd_t        exp_q[$];
  rsp_t        rsp_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] csr_q[$];
  logic [31:0] rd_dr_q[$];
  int unsigned wait_cycles = 0;
  int unsigned unstable = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  pmci_spi_csr_seq #(.SPI_BA(BA), .POLL_GAP(GAP), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avmm_address(avmm_address), .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_writedata(avmm_writedata), .avmm_waitrequest(avmm_waitrequest),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back('{rsp_err, rsp_rdata, cyc});
  end

  // AVMM slave: samples at negedge, drives waitrequest/readdatavalid 1 time unit after posedge.
  initial begin
    logic        new_cmd;
    logic        acc_rd;
    logic [31:0] acc_addr;
    int unsigned hold;
    cmd_t        snap;
    new_cmd = 1'b1; hold = 0; acc_addr = 32'h0;
    snap = '{1'b0, 32'h0, 32'h0, 0};
    avmm_waitrequest = 1'b0; avmm_readdatavalid = 1'b0; avmm_readdata = 32'h0;
    forever begin
      @(negedge clk);
      acc_rd = 1'b0;
      if (rst) begin
        new_cmd = 1'b1;
      end else if (avmm_read || avmm_write) begin
        if (avmm_waitrequest) begin
          if (avmm_address !== snap.addr || avmm_write !== snap.wr ||
              (avmm_write ? avmm_writedata : 32'h0) !== snap.data) unstable++;
        end else begin
          act_q.push_back('{avmm_write, avmm_address, avmm_write ? avmm_writedata : 32'h0, cyc});
          acc_rd   = avmm_read;
          acc_addr = avmm_address;
          new_cmd  = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      avmm_readdatavalid = 1'b0;
      if (acc_rd) begin
        avmm_readdatavalid = 1'b1;
        avmm_readdata = 32'hBAD0_0000;
        if (acc_addr == BA) begin
          avmm_readdata = 32'h0;
          if (csr_q.size() != 0) avmm_readdata = csr_q.pop_front();
        end else if (acc_addr == BA + 32'h8) begin
          if (rd_dr_q.size() != 0) avmm_readdata = rd_dr_q.pop_front();
        end
      end
      if (avmm_read || avmm_write) begin
        if (new_cmd) begin
          new_cmd = 1'b0;
          hold = wait_cycles;
          snap = '{avmm_write, avmm_address, avmm_write ? avmm_writedata : 32'h0, 0};
        end
        if (hold > 0) begin
          avmm_waitrequest = 1'b1;
          hold--;
        end else begin
          avmm_waitrequest = 1'b0;
        end
      end else begin
        avmm_waitrequest = 1'b0;
      end
    end
  end

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d, 0});
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{1'b0, a, 32'h0, 0});
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int unsigned acc_cyc, output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    acc_cyc = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        acc_cyc = cyc + 1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int unsigned n = 0;
    while (rsp_q.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (rsp_q.size() != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h44; req_wdata = 32'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, avmm_read, avmm_write, avmm_address, avmm_writedata}
        !== 100'h0) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b re=%b rd=%h r=%b w=%b a=%h wd=%h", rsp_valid,
               rsp_err, rsp_rdata, avmm_read, avmm_write, avmm_address, avmm_writedata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b exp 1", req_ready);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (act_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_req_dropped got cmds=%0d rsps=%0d exp 0/0", act_q.size(), rsp_q.size());
    end
    act_q.delete(); rsp_q.delete();
  endtask

  task automatic test_write();
    int unsigned acc;
    bit ok;
    rsp_t r, e;
    csr_q.push_back(32'h0);
    exp_wr(BA + 32'h4, 32'h100); exp_wr(BA + 32'hC, 32'hDEADBEEF); exp_wr(BA, 32'h1); exp_rd(BA);
    exp_rsp_q.push_back('{1'b0, 32'h0, 6});
    do_req(1'b1, 32'h100, 32'hDEADBEEF, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata) begin
        errors++;
        $display("FAIL write_rsp got err=%b rdata=%h exp err=%b rdata=%h", r.err, r.rdata, e.err,
                 e.rdata);
      end
      checks++;
      if (r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL write_latency got %0d exp %0d", r.cyc - acc, e.cyc);
      end
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr ||
          act_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL write_cmd%0d got %b/%h/%h exp %b/%h/%h", i, act_q[i].wr, act_q[i].addr,
                 act_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete();
  endtask

  task automatic test_read_polls();
    int unsigned acc;
    bit ok;
    rsp_t r, e;
    csr_q.push_back(32'h4); csr_q.push_back(32'h4); csr_q.push_back(32'h4); csr_q.push_back(32'h0);
    rd_dr_q.push_back(32'hA5A5_5A5A);
    exp_wr(BA + 32'h4, 32'h200); exp_wr(BA, 32'h2);
    for (int i = 0; i < 4; i++) exp_rd(BA);
    exp_rd(BA + 32'h8);
    exp_rsp_q.push_back('{1'b0, 32'hA5A5_5A5A, 7 + 3 * (GAP + 2)});
    do_req(1'b0, 32'h200, 32'h0, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata) begin
        errors++;
        $display("FAIL read_rsp got err=%b rdata=%h exp err=%b rdata=%h", r.err, r.rdata, e.err,
                 e.rdata);
      end
      checks++;
      if (r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL read_latency got %0d exp %0d", r.cyc - acc, e.cyc);
      end
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL read_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr ||
          act_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL read_cmd%0d got %b/%h/%h exp %b/%h/%h", i, act_q[i].wr, act_q[i].addr,
                 act_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    for (int i = 3; i < 6 && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].cyc - act_q[i-1].cyc !== GAP + 2) begin
        errors++;
        $display("FAIL read_poll_gap%0d got %0d exp %0d", i, act_q[i].cyc - act_q[i-1].cyc,
                 GAP + 2);
      end
    end
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete(); rd_dr_q.delete();
  endtask

  task automatic test_timeout();
    int unsigned acc;
    bit ok;
    rsp_t r, e;
    for (int i = 0; i < 8; i++) csr_q.push_back(32'h4);
    rd_dr_q.push_back(32'h1234_5678);
    exp_wr(BA + 32'h4, 32'h300); exp_wr(BA, 32'h2);
    for (int i = 0; i < PMAX; i++) exp_rd(BA);
    exp_rsp_q.push_back('{1'b1, 32'h0, 5 + (PMAX - 1) * (GAP + 2)});
    do_req(1'b0, 32'h300, 32'h0, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata || r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL timeout_rsp got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r.err, r.rdata, r.cyc - acc, e.err, e.rdata, e.cyc);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL timeout_cmd%0d got %b/%h exp %b/%h", i, act_q[i].wr, act_q[i].addr,
                 exp_q[i].wr, exp_q[i].addr);
      end
    end
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete(); rd_dr_q.delete();
  endtask

  task automatic test_csr_error();
    int unsigned acc;
    bit ok;
    rsp_t r, e;
    csr_q.push_back(32'h8);
    rd_dr_q.push_back(32'h1111_2222);
    exp_wr(BA + 32'h4, 32'h400); exp_wr(BA, 32'h2); exp_rd(BA);
    exp_rsp_q.push_back('{1'b1, 32'h0, 5});
    do_req(1'b0, 32'h400, 32'h0, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL csr_error_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata || r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL csr_error_rsp got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r.err, r.rdata, r.cyc - acc, e.err, e.rdata, e.cyc);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL csr_error_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr) begin
        errors++;
        $display("FAIL csr_error_cmd%0d got %b/%h exp %b/%h", i, act_q[i].wr, act_q[i].addr,
                 exp_q[i].wr, exp_q[i].addr);
      end
    end
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete(); rd_dr_q.delete();
  endtask

  task automatic test_waitrequest();
    int unsigned acc;
    bit ok;
    rsp_t r, e;
    wait_cycles = 5;
    unstable = 0;
    csr_q.push_back(32'h0);
    exp_wr(BA + 32'h4, 32'h0ABC_0000); exp_wr(BA + 32'hC, 32'h0F0F_1234); exp_wr(BA, 32'h1);
    exp_rd(BA);
    exp_rsp_q.push_back('{1'b0, 32'h0, 6 + 4 * 5});
    do_req(1'b1, 32'h0ABC_0000, 32'h0F0F_1234, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata || r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL wait_rsp got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r.err, r.rdata, r.cyc - acc, e.err, e.rdata, e.cyc);
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL wait_stable got %0d changes exp 0", unstable);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wait_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr ||
          act_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL wait_cmd%0d got %b/%h/%h exp %b/%h/%h", i, act_q[i].wr, act_q[i].addr,
                 act_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    wait_cycles = 0;
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete();
  endtask

  task automatic test_reset_mid();
    int unsigned acc;
    int unsigned n = 0;
    bit ok;
    rsp_t r, e;
    csr_q.push_back(32'h4); csr_q.push_back(32'h4);
    do_req(1'b0, 32'h500, 32'h0, acc, ok);
    while (act_q.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (act_q.size() != 3) begin
      errors++;
      $display("FAIL abort_first_poll got %0d cmds exp 3", act_q.size());
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || act_q.size() != 3) begin
      errors++;
      $display("FAIL abort_quiet got rsps=%0d cmds=%0d exp 0/3", rsp_q.size(), act_q.size());
    end
    act_q.delete(); rsp_q.delete(); csr_q.delete();
    csr_q.push_back(32'h0);
    exp_wr(BA + 32'h4, 32'h600); exp_wr(BA + 32'hC, 32'hCAFE_F00D); exp_wr(BA, 32'h1);
    exp_rd(BA);
    exp_rsp_q.push_back('{1'b0, 32'h0, 6});
    do_req(1'b1, 32'h600, 32'hCAFE_F00D, acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_new_handshake got timeout exp response");
    end else begin
      r = rsp_q.pop_front(); e = exp_rsp_q.pop_front();
      checks++;
      if (r.err !== e.err || r.rdata !== e.rdata || r.cyc - acc !== e.cyc) begin
        errors++;
        $display("FAIL abort_new_rsp got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r.err, r.rdata, r.cyc - acc, e.err, e.rdata, e.cyc);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_single_rsp got %0d extra exp 0", rsp_q.size());
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_cmd_count got %0d exp %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].wr !== exp_q[i].wr || act_q[i].addr !== exp_q[i].addr ||
          act_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL abort_cmd%0d got %b/%h/%h exp %b/%h/%h", i, act_q[i].wr, act_q[i].addr,
                 act_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    act_q.delete(); exp_q.delete(); exp_rsp_q.delete(); csr_q.delete(); rsp_q.delete();
  endtask

  task automatic test_back_to_back();
    int unsigned acc1, acc2;
    int unsigned n = 0;
    bit ok1, ok2;
    rsp_t r1, r2, e;
    csr_q.push_back(32'h0); csr_q.push_back(32'h0);
    rd_dr_q.push_back(32'h1357_9BDF); rd_dr_q.push_back(32'h2468_ACE0);
    exp_rsp_q.push_back('{1'b0, 32'h1357_9BDF, 7});
    exp_rsp_q.push_back('{1'b0, 32'h2468_ACE0, 7});
    do_req(1'b0, 32'h700, 32'h0, acc1, ok1);
    do_req(1'b0, 32'h704, 32'h0, acc2, ok2);
    while (rsp_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok1 || !ok2 || rsp_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_handshake got acc=%b%b rsps=%0d exp 11/2", ok1, ok2, rsp_q.size());
    end else begin
      r1 = rsp_q.pop_front(); r2 = rsp_q.pop_front();
      e = exp_rsp_q.pop_front();
      checks++;
      if (r1.err !== e.err || r1.rdata !== e.rdata || r1.cyc - acc1 !== e.cyc) begin
        errors++;
        $display("FAIL b2b_rsp1 got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r1.err, r1.rdata, r1.cyc - acc1, e.err, e.rdata, e.cyc);
      end
      e = exp_rsp_q.pop_front();
      checks++;
      if (r2.err !== e.err || r2.rdata !== e.rdata || r2.cyc - acc2 !== e.cyc) begin
        errors++;
        $display("FAIL b2b_rsp2 got err=%b rdata=%h lat=%0d exp err=%b rdata=%h lat=%0d",
                 r2.err, r2.rdata, r2.cyc - acc2, e.err, e.rdata, e.cyc);
      end
      checks++;
      if (acc2 !== r1.cyc + 1) begin
        errors++;
        $display("FAIL b2b_accept got cycle %0d exp %0d", acc2, r1.cyc + 1);
      end
    end
    act_q.delete(); exp_rsp_q.delete(); csr_q.delete(); rd_dr_q.delete(); rsp_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_polls();
    test_timeout();
    test_csr_error();
    test_waitrequest();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
